// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, device-clocked
// shift-out of data/parity/stop, ACK check and return-to-idle, guarded by a frame watchdog.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    RTS       = 3'd2,
    SHIFT     = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } state_t;

  state_t state, state_nx;

  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic          fe;
  logic [7:0]    sh, sh_nx;
  logic          par, par_nx;
  logic [3:0]    n, n_nx;
  logic [IW-1:0] inh_cnt, inh_nx;
  logic [TW-1:0] wd_cnt, wd_nx;
  logic          clk_oe_nx, data_oe_nx, done_nx, error_nx;
  logic          wd_active, wd_expired;

  // Line level for frame position idx: 1..8 data LSB first, 9 parity, otherwise released.
  function automatic logic frame_level(input logic [3:0] idx, input logic [7:0] b, input logic p);
    logic [3:0] i;
    logic       lvl;
    i = idx - 4'd1;
    if (idx >= 4'd1 && idx <= 4'd8) begin
      lvl = b[i[2:0]];
    end else if (idx == 4'd9) begin
      lvl = p;
    end else begin
      lvl = 1'b1;
    end
    return lvl;
  endfunction

  assign fe         = clk_prev & ~clk_s2;
  assign wd_active  = (state == RTS) || (state == SHIFT) || (state == ACK) || (state == WAIT_IDLE);
  assign wd_expired = wd_active && (wd_cnt == TW'(TIMEOUT_CYCLES - 1));

  // A finishing pulse keeps the requester out for one more cycle even though the FSM is already idle.
  assign tx_ready = (state == IDLE) & ~tx_done & ~tx_error;

  // Pin synchronizers and falling-edge history.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk_in;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data_in;
      dat_s2   <= dat_s1;
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sh          <= 8'd0;
      par         <= 1'b0;
      n           <= 4'd0;
      inh_cnt     <= '0;
      wd_cnt      <= '0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
    end else begin
      state       <= state_nx;
      sh          <= sh_nx;
      par         <= par_nx;
      n           <= n_nx;
      inh_cnt     <= inh_nx;
      wd_cnt      <= wd_nx;
      ps2_clk_oe  <= clk_oe_nx;
      ps2_data_oe <= data_oe_nx;
      tx_done     <= done_nx;
      tx_error    <= error_nx;
    end
  end

  // Next-state and next-output decode; outputs are computed for the state being entered.
  always_comb begin
    state_nx   = state;
    sh_nx      = sh;
    par_nx     = par;
    n_nx       = n;
    inh_nx     = inh_cnt;
    wd_nx      = wd_cnt;
    clk_oe_nx  = 1'b0;
    data_oe_nx = 1'b0;
    done_nx    = 1'b0;
    error_nx   = 1'b0;

    case (state)
      IDLE: begin
        if (tx_valid && tx_ready) begin
          state_nx  = INHIBIT;
          sh_nx     = tx_data;
          par_nx    = ~^tx_data;
          inh_nx    = '0;
          clk_oe_nx = 1'b1;
        end else begin
          state_nx = IDLE;
        end
      end

      INHIBIT: begin
        inh_nx    = inh_cnt + IW'(1);
        clk_oe_nx = 1'b1;
        if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
          state_nx   = RTS;
          clk_oe_nx  = 1'b0;
          data_oe_nx = 1'b1;
          wd_nx      = '0;
          n_nx       = 4'd0;
        end else begin
          state_nx = INHIBIT;
        end
      end

      RTS: begin
        wd_nx      = wd_cnt + TW'(1);
        data_oe_nx = 1'b1;
        if (fe) begin
          state_nx   = SHIFT;
          n_nx       = 4'd1;
          data_oe_nx = ~frame_level(4'd1, sh, par);
        end else begin
          state_nx = RTS;
        end
      end

      SHIFT: begin
        wd_nx      = wd_cnt + TW'(1);
        data_oe_nx = ~frame_level(n, sh, par);
        if (fe) begin
          n_nx       = n + 4'd1;
          data_oe_nx = ~frame_level(n + 4'd1, sh, par);
          if (n + 4'd1 == 4'd10) begin
            state_nx = ACK;
          end else begin
            state_nx = SHIFT;
          end
        end else begin
          state_nx = SHIFT;
        end
      end

      ACK: begin
        wd_nx = wd_cnt + TW'(1);
        if (fe) begin
          if (dat_s2 == 1'b0) begin
            state_nx = WAIT_IDLE;
          end else begin
            state_nx = IDLE;
            error_nx = 1'b1;
          end
        end else begin
          state_nx = ACK;
        end
      end

      WAIT_IDLE: begin
        wd_nx = wd_cnt + TW'(1);
        if (clk_s2 && dat_s2) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = WAIT_IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
      end
    endcase

    // Watchdog wins over any edge handled above in the same cycle.
    if (wd_expired) begin
      state_nx   = IDLE;
      clk_oe_nx  = 1'b0;
      data_oe_nx = 1'b0;
      done_nx    = 1'b0;
      error_nx   = 1'b1;
    end else begin
      error_nx = error_nx;
    end
  end

endmodule
